elevator_ctrl: RTL and testbench

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

---
 rtl/elevator_pkg.sv | 17 +
 rtl/elevator_req_tracker.sv | 74 +++++++
 rtl/elevator_ctrl.sv | 164 ++++++++++++++++
 tb/tb_elevator_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller: the car state encoding,
// which doubles as the externally visible status code, and a small sizing helper.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_MOVING_UP   = 2'b01,
        ST_MOVING_DOWN = 2'b10,
        ST_DOOR_OPEN   = 2'b11
    } elev_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_req_tracker.sv
// Holds one pending bit per floor.
// Reports whether requests exist at, above or below two floors: the floor the
// car is at, and the look-ahead floor it is about to step onto.
module elevator_req_tracker
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  setValid_i,
    input  logic [FLOOR_W-1:0]    setFloor_i,
    input  logic                  clrValid_i,
    input  logic [FLOOR_W-1:0]    clrFloor_i,
    input  logic [FLOOR_W-1:0]    curFloor_i,
    input  logic [FLOOR_W-1:0]    lookFloor_i,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  reqHere_o,
    output logic                  reqAbove_o,
    output logic                  reqBelow_o,
    output logic                  lookHere_o,
    output logic                  lookAbove_o,
    output logic                  lookBelow_o
);

    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;

    // Clear the served floor, then set a newly accepted one; the controller never asks for both on one floor.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (clrValid_i && (clrFloor_i == FLOOR_W'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (setValid_i && (setFloor_i == FLOOR_W'(i))) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    // Pending register, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Position flags relative to the current floor and to the look-ahead floor.
    always_comb begin
        reqHere_o   = 1'b0;
        reqAbove_o  = 1'b0;
        reqBelow_o  = 1'b0;
        lookHere_o  = 1'b0;
        lookAbove_o = 1'b0;
        lookBelow_o = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i]) begin
                if (i == int'(curFloor_i))  reqHere_o   = 1'b1;
                if (i >  int'(curFloor_i))  reqAbove_o  = 1'b1;
                if (i <  int'(curFloor_i))  reqBelow_o  = 1'b1;
                if (i == int'(lookFloor_i)) lookHere_o  = 1'b1;
                if (i >  int'(lookFloor_i)) lookAbove_o = 1'b1;
                if (i <  int'(lookFloor_i)) lookBelow_o = 1'b1;
            end
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller using SCAN scheduling.
// The car keeps moving in its current direction while requests lie ahead.
// A step onto a pending floor opens the door for a fixed time.
// Requests for the floor where the door is open extend the door time instead of queuing.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [1:0]            elevator_status,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  arrived
);

    localparam int TRAV_W = cntWidth(TRAVEL_CYCLES);
    localparam int DOOR_W = cntWidth(DOOR_CYCLES);
    localparam logic [TRAV_W-1:0]  TRAV_LAST  = TRAV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]  DOOR_LAST  = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

    elev_state_e         state_q,     state_d;
    logic [FLOOR_W-1:0]  floor_q,     floor_d;
    logic [TRAV_W-1:0]   travelCnt_q, travelCnt_d;
    logic [DOOR_W-1:0]   doorCnt_q,   doorCnt_d;
    logic                lastUp_q,    lastUp_d;
    logic                arrived_q,   arrived_d;

    logic [FLOOR_W-1:0]  lookFloor;
    logic                clrValid;
    logic [FLOOR_W-1:0]  clrFloor;
    logic                reqInRange;
    logic                absorbReq;
    logic                setValid;
    logic                reqHere, reqAbove, reqBelow;
    logic                lookHere, lookAbove, lookBelow;

    // A request for the floor where the door is, or is about to be, open is absorbed rather than queued.
    assign reqInRange = (int'(req_floor) < NUM_FLOORS);
    assign absorbReq  = (state_d == ST_DOOR_OPEN) && (req_floor == floor_d);
    assign setValid   = req_valid && reqInRange && !absorbReq;

    elevator_req_tracker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .setValid_i  (setValid),
        .setFloor_i  (req_floor),
        .clrValid_i  (clrValid),
        .clrFloor_i  (clrFloor),
        .curFloor_i  (floor_q),
        .lookFloor_i (lookFloor),
        .pending_o   (pending),
        .reqHere_o   (reqHere),
        .reqAbove_o  (reqAbove),
        .reqBelow_o  (reqBelow),
        .lookHere_o  (lookHere),
        .lookAbove_o (lookAbove),
        .lookBelow_o (lookBelow)
    );

    // The floor the car would step onto next, saturated at the shaft ends.
    always_comb begin
        lookFloor = floor_q;
        if ((state_q == ST_MOVING_UP) && (floor_q != TOP_FLOOR)) begin
            lookFloor = floor_q + 1'b1;
        end else if ((state_q == ST_MOVING_DOWN) && (floor_q != '0)) begin
            lookFloor = floor_q - 1'b1;
        end
    end

    // Next-state logic: scheduling decisions, travel/door timing and pending clears.
    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        travelCnt_d = travelCnt_q;
        doorCnt_d   = doorCnt_q;
        lastUp_d    = lastUp_q;
        arrived_d   = 1'b0;
        clrValid    = 1'b0;
        clrFloor    = floor_q;
        unique case (state_q)
            ST_IDLE: begin
                if (reqHere) begin
                    state_d   = ST_DOOR_OPEN;
                    doorCnt_d = '0;
                    arrived_d = 1'b1;
                    clrValid  = 1'b1;
                end else if ((lastUp_q && reqAbove) || (!lastUp_q && !reqBelow && reqAbove)) begin
                    state_d     = ST_MOVING_UP;
                    travelCnt_d = '0;
                    lastUp_d    = 1'b1;
                end else if (reqBelow) begin
                    state_d     = ST_MOVING_DOWN;
                    travelCnt_d = '0;
                    lastUp_d    = 1'b0;
                end
            end
            ST_MOVING_UP, ST_MOVING_DOWN: begin
                if (travelCnt_q == TRAV_LAST) begin
                    travelCnt_d = '0;
                    floor_d     = lookFloor;
                    if (lookHere) begin
                        state_d   = ST_DOOR_OPEN;
                        doorCnt_d = '0;
                        arrived_d = 1'b1;
                        clrValid  = 1'b1;
                        clrFloor  = lookFloor;
                    end else if ((state_q == ST_MOVING_UP) ? !lookAbove : !lookBelow) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    travelCnt_d = travelCnt_q + 1'b1;
                end
            end
            ST_DOOR_OPEN: begin
                if (req_valid && (req_floor == floor_q)) begin
                    doorCnt_d = '0;
                end else if (doorCnt_q == DOOR_LAST) begin
                    doorCnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    doorCnt_d = doorCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset parks the car at floor 0 heading up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            floor_q     <= '0;
            travelCnt_q <= '0;
            doorCnt_q   <= '0;
            lastUp_q    <= 1'b1;
            arrived_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            travelCnt_q <= travelCnt_d;
            doorCnt_q   <= doorCnt_d;
            lastUp_q    <= lastUp_d;
            arrived_q   <= arrived_d;
        end
    end

    assign current_floor   = floor_q;
    assign elevator_status = state_q;
    assign arrived         = arrived_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl with five floors and a 3-bit floor index.
// Every cycle is compared against an event-time reference model.
// Directed timing scenarios come first, followed by randomized requests and resets.
module tb_elevator_ctrl;

    localparam int NF   = 5;
    localparam int FW   = 3;
    localparam int TRAV = 4;
    localparam int DOOR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic [FW-1:0] current_floor;
    logic [1:0]    elevator_status;
    logic [NF-1:0] pending;
    logic          arrived;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state: status code, floor, requests and absolute event times.
    int mState;
    int mFloor;
    int mLastUp;
    int mArrived;
    int mCycle;
    int mStepAt;
    int mDoorCloseAt;
    bit mPend [NF];

    elevator_ctrl #(
        .NUM_FLOORS    (NF),
        .FLOOR_W       (FW),
        .TRAVEL_CYCLES (TRAV),
        .DOOR_CYCLES   (DOOR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_floor       (req_floor),
        .current_floor   (current_floor),
        .elevator_status (elevator_status),
        .pending         (pending),
        .arrived         (arrived)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, mCycle);
        end
    endtask

    function automatic int pendMask();
        int m = 0;
        for (int i = 0; i < NF; i++) if (mPend[i]) m |= (1 << i);
        return m;
    endfunction

    function automatic bit anyAbove(input int fl);
        for (int i = fl + 1; i < NF; i++) if (mPend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit anyBelow(input int fl);
        for (int i = 0; i < fl; i++) if (mPend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        mState   = 0;
        mFloor   = 0;
        mLastUp  = 1;
        mArrived = 0;
        for (int i = 0; i < NF; i++) mPend[i] = 1'b0;
    endtask

    task automatic openDoor();
        mState             = 3;
        mPend[mFloor]      = 1'b0;
        mArrived           = 1;
        mDoorCloseAt       = mCycle + DOOR;
    endtask

    task automatic startMove(input int dir);
        mState  = dir;
        mStepAt = mCycle + TRAV;
        mLastUp = (dir == 1) ? 1 : 0;
    endtask

    // One rising edge of the reference model; decisions see the requests held before this edge.
    task automatic modelEdge(input bit v, input int f);
        bit accept;
        mCycle++;
        mArrived = 0;
        accept   = v && (f < NF);
        case (mState)
            0: begin
                if (mPend[mFloor]) openDoor();
                else if (mLastUp == 1 && anyAbove(mFloor)) startMove(1);
                else if (mLastUp == 0 && anyBelow(mFloor)) startMove(2);
                else if (anyAbove(mFloor)) startMove(1);
                else if (anyBelow(mFloor)) startMove(2);
            end
            1, 2: begin
                if (mCycle == mStepAt) begin
                    mFloor += (mState == 1) ? 1 : -1;
                    if (mPend[mFloor]) openDoor();
                    else if ((mState == 1 && anyAbove(mFloor)) || (mState == 2 && anyBelow(mFloor)))
                        mStepAt = mCycle + TRAV;
                    else mState = 0;
                end
            end
            default: begin
                if (accept && f == mFloor) mDoorCloseAt = mCycle + DOOR;
                else if (mCycle == mDoorCloseAt) mState = 0;
            end
        endcase
        if (accept && !(mState == 3 && f == mFloor)) mPend[f] = 1'b1;
    endtask

    task automatic checkAll(input string ph);
        checkOutput({ph, ".floor"},   int'(current_floor),   mFloor);
        checkOutput({ph, ".status"},  int'(elevator_status), mState);
        checkOutput({ph, ".pending"}, int'(pending),         pendMask());
        checkOutput({ph, ".arrived"}, int'(arrived),         mArrived);
    endtask

    // Drive one cycle of request inputs, advance the model on the edge, compare just after it.
    task automatic applyStimulus(input bit v, input int f);
        @(negedge clk);
        req_valid = v;
        req_floor = FW'(f);
        @(posedge clk);
        modelEdge(v, f);
        #1;
        checkAll("cyc");
    endtask

    // Assert reset between edges, check it acts at once, hold it over two edges with requests present.
    task automatic asyncReset(input string ph);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll({ph, ".async"});
        repeat (2) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_floor = FW'($urandom_range(0, NF - 1));
            @(posedge clk);
            mCycle++;
            #1;
            checkAll({ph, ".held"});
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
    endtask

    // Idle the inputs until the model reaches the given status and floor, within a cycle budget.
    task automatic runUntil(input string ph, input int st, input int fl, input int budget);
        int n = 0;
        while (!(mState == st && mFloor == fl) && n < budget) begin
            applyStimulus(1'b0, 0);
            n++;
        end
        checkOutput({ph, ".reach"}, int'(mState == st && mFloor == fl), 1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_floor = '0;
        mCycle    = 0;
        modelReset();
        #1;
        checkAll("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Request floor 2 from floor 0 and check the documented timeline.
        applyStimulus(1'b1, 2);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 0);
            if (k == 1)  checkOutput("t1.status",  int'(elevator_status), 1);
            if (k == 4)  checkOutput("t4.floor",   int'(current_floor),   0);
            if (k == 5)  checkOutput("t5.floor",   int'(current_floor),   1);
            if (k == 9) begin
                checkOutput("t9.floor",   int'(current_floor),   2);
                checkOutput("t9.status",  int'(elevator_status), 3);
                checkOutput("t9.arrived", int'(arrived),         1);
            end
            if (k == 10) checkOutput("t10.arrived", int'(arrived), 0);
            if (k == 12) begin
                checkOutput("t12.status",  int'(elevator_status), 0);
                checkOutput("t12.pending", int'(pending),         0);
            end
        end

        // Out-of-range floor index is dropped.
        applyStimulus(1'b1, 5);
        checkOutput("oor.pending", int'(pending), 0);
        applyStimulus(1'b0, 0);
        checkOutput("oor.status", int'(elevator_status), 0);

        // Door at floor 1 held open by repeated requests for that floor.
        applyStimulus(1'b1, 1);
        runUntil("door1", 3, 1, 40);
        repeat (4) begin
            applyStimulus(1'b1, 1);
            checkOutput("hold.status", int'(elevator_status), 3);
            checkOutput("hold.pend1",  int'(pending[1]),      0);
            applyStimulus(1'b0, 0);
            checkOutput("hold.status2", int'(elevator_status), 3);
        end
        applyStimulus(1'b0, 0);
        checkOutput("close.r2", int'(elevator_status), 3);
        applyStimulus(1'b0, 0);
        checkOutput("close.r3", int'(elevator_status), 0);

        // Reset while moving down past floor 2, then serve floor 1 from floor 0.
        applyStimulus(1'b1, 3);
        runUntil("top", 3, 3, 40);
        runUntil("topIdle", 0, 3, 10);
        applyStimulus(1'b1, 0);
        runUntil("down2", 2, 2, 40);
        asyncReset("midtravel");
        applyStimulus(1'b1, 1);
        runUntil("serve1", 3, 1, 40);
        checkOutput("serve1.floor", int'(current_floor), 1);

        // Randomized requests, including out-of-range indices and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                asyncReset("rnd");
            end else begin
                applyStimulus($urandom_range(0, 4) == 0, int'($urandom_range(0, 7)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
